// File: rtl/cfg_stream_loader.sv
// Serial configuration chain loader: takes bitstream bytes over valid/ready,
// shifts them out LSB-first as a cfg_clk/cfg_value pair and emits exactly
// CHAIN_LEN rising edges of cfg_clk per load.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | no load in progress, waiting for start_i
// S_WAIT_BYTE | ready for the next bitstream byte, cfg_clk held low
// S_LOW       | cfg_clk low, current bit presented (setup phase)
// S_HIGH      | cfg_clk high, bit held (hold phase)
// S_DONE      | one-cycle completion pulse
module cfg_stream_loader #(
    parameter int CHAIN_LEN = 5,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       cfg_clk_o,
    output logic       cfg_value_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int SENT_W  = $clog2(CHAIN_LEN + 1);
    localparam int PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LOAD = PHASE_W'(CLK_DIV - 1);
    localparam logic [SENT_W-1:0]  SENT_LAST  = SENT_W'(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [SENT_W-1:0]  sent_q, sent_d;
    logic [SENT_W-1:0]  sent_next;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               ready_q, ready_d;
    logic               cfg_clk_q, cfg_clk_d;
    logic               cfg_value_q, cfg_value_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State, counters and registered outputs; async reset clears everything.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            sent_q      <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            ready_q     <= 1'b0;
            cfg_clk_q   <= 1'b0;
            cfg_value_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sent_q      <= sent_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            ready_q     <= ready_d;
            cfg_clk_q   <= cfg_clk_d;
            cfg_value_q <= cfg_value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // registered yet aligned with the state they describe.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sent_d      = sent_q;
        sent_next   = sent_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        cfg_value_d = cfg_value_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sent_d  = '0;
                    state_d = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                // ready_q is high throughout this state, so this is the handshake
                if (data_valid_i && ready_q) begin
                    shreg_d     = data_i;
                    bit_idx_d   = '0;
                    phase_d     = PHASE_LOAD;
                    cfg_value_d = data_i[0];
                    state_d     = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_q == '0) begin
                    phase_d = PHASE_LOAD;
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
            S_HIGH: begin
                if (phase_q == '0) begin
                    sent_next = (sent_q == SENT_LAST) ? sent_q : sent_q + SENT_W'(1);
                    sent_d    = sent_next;
                    if (sent_next == SENT_LAST) begin
                        state_d = S_DONE;
                    end else if (bit_idx_q == 3'd7) begin
                        state_d = S_WAIT_BYTE;
                    end else begin
                        // next bit goes out together with the falling edge
                        bit_idx_d   = bit_idx_q + 3'd1;
                        shreg_d     = shreg_q >> 1;
                        cfg_value_d = shreg_q[1];
                        phase_d     = PHASE_LOAD;
                        state_d     = S_LOW;
                    end
                end else begin
                    phase_d = phase_q - PHASE_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d   = (state_d == S_WAIT_BYTE);
        cfg_clk_d = (state_d == S_HIGH);
        busy_d    = (state_d == S_WAIT_BYTE) || (state_d == S_LOW) || (state_d == S_HIGH);
        done_d    = (state_d == S_DONE);
    end

    assign data_ready_o = ready_q;
    assign cfg_clk_o    = cfg_clk_q;
    assign cfg_value_o  = cfg_value_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
